// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: debounced push-button stepper that drives the count RM's count_en value.
//
// Ports:
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset, released synchronously by the flops
//   btn_in_i      in   1      raw push-button, active high, asynchronous to clk
//   clr_i         in   1      synchronous clear of the step value to VAL_INIT (wins over a pulse)
//   press_pulse_o out  1      one-cycle pulse per accepted press (and per auto-repeat)
//   btn_level_o   out  1      debounced button level
//   step_val_o    out  VAL_W  step value, incremented modulo 2**VAL_W on every pulse
//
// Build option: define BTN_AUTO_REPEAT_EN to add hold-to-repeat pulses while the
// button stays held; without it exactly one pulse is produced per debounced press.
module btn_step_ctrl #(
    parameter int unsigned       DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned       CNT_W           = 21,
    parameter int unsigned       VAL_W           = 4,
    parameter logic [VAL_W-1:0]  VAL_INIT        = '0,
    parameter int unsigned       REPEAT_DELAY    = 1000000,
    parameter int unsigned       REPEAT_PERIOD   = 200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in_i,
    input  logic             clr_i,
    output logic             press_pulse_o,
    output logic             btn_level_o,
    output logic [VAL_W-1:0] step_val_o
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1 ||
        (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_param_check
        $error("btn_step_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_e;

    // The counter is checked before its increment, so the final wait cycle sits at
    // DEBOUNCE_CYCLES-2; together with the entry cycle that makes DEBOUNCE_CYCLES
    // consecutive stable samples of btn_s.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, btn_s_q;
    logic               pulse_q, pulse_d;
    logic               level_q, level_d;
    logic [VAL_W-1:0]   step_q, step_d;
    logic               accept;
    logic               rpt_fire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s_q) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!btn_s_q) state_d = REL_WAIT;
            end
            REL_WAIT: begin
                if (btn_s_q) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DELAY  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RPT_PERIOD = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic             rep_q, rep_d;

    // Counts only while HELD persists; any exit (or re-entry from REL_WAIT) restarts
    // the initial delay. rep_q switches the target from the delay to the period.
    always_comb begin
        rpt_d    = '0;
        rep_d    = 1'b0;
        rpt_fire = 1'b0;
        if (state_q == HELD && btn_s_q) begin
            rpt_d = rpt_q + CNT_W'(1);
            rep_d = rep_q;
            if (rpt_d == (rep_q ? RPT_PERIOD : RPT_DELAY)) begin
                rpt_fire = 1'b1;
                rpt_d    = '0;
                rep_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            rpt_q <= rpt_d;
            rep_q <= rep_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        pulse_d = accept | rpt_fire;
        level_d = (state_d == HELD) || (state_d == REL_WAIT);
        step_d  = clr_i ? VAL_INIT : pulse_d ? step_q + VAL_W'(1) : step_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            step_q  <= VAL_INIT;
        end else begin
            sync1_q <= btn_in_i;
            btn_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            step_q  <= step_d;
        end
    end

    assign press_pulse_o = pulse_q;
    assign btn_level_o   = level_q;
    assign step_val_o    = step_q;

endmodule
